// File: rtl/data_plane_tx_param.sv
// Data-plane transmitter: FIFO-buffered payload, header + PKT_LEN burst per start.
// Optional trailing XOR checksum word when DP_TX_CHECKSUM_EN is defined.
module data_plane_tx_param #(
  parameter int DATA_W  = 16,
  parameter int NODE_W  = 16,
  parameter int DEPTH   = 16,
  parameter int PKT_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gpp_trf_dp,
  input  logic [DATA_W-1:0]          gpp_tx_data,
  input  logic [NODE_W-1:0]          node_id,
  input  logic [NODE_W-1:0]          dest_node,
  input  logic                       data_tx_flag,
  output logic [NODE_W+DATA_W-1:0]   data_tx_packet,
  output logic                       data_tx_valid,
  output logic                       data_tx_complete_flag,
  output logic                       data_tx_reject,
  output logic [$clog2(DEPTH):0]     buf_level,
  output logic                       buf_full,
  output logic                       buf_empty,
  output logic                       buf_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = NODE_W + DATA_W;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] PLEN_L  = LW'(PKT_LEN);
  localparam logic [LW-1:0] LAST_L  = LW'(PKT_LEN - 1);

`ifdef DP_TX_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_PAYLOAD, S_CSUM, S_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_HEADER, S_PAYLOAD, S_DONE
  } state_t;
`endif

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic [NODE_W-1:0] dest_q, dest_d;
  logic [LW-1:0]     beat_q, beat_d;
  logic [PW-1:0]     pkt_q, pkt_d;
  logic              valid_q, valid_d;
  logic              cmpl_q, cmpl_d;
  logic              rej_q, rej_d;
`ifdef DP_TX_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  logic              full;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] rd_word;

  assign full    = (level_q == DEPTH_L);
  assign wr_en   = gpp_trf_dp && !full;
  assign rd_word = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    beat_d  = beat_q;
    pkt_d   = '0;
    valid_d = 1'b0;
    cmpl_d  = 1'b0;
    rej_d   = 1'b0;
    rd_en   = 1'b0;
`ifdef DP_TX_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (data_tx_flag) begin
          if (level_q >= PLEN_L) begin
            dest_d  = dest_node;
            beat_d  = '0;
            state_d = S_HEADER;
`ifdef DP_TX_CHECKSUM_EN
            csum_d  = '0;
`endif
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      S_HEADER: begin
        pkt_d   = {dest_q, node_id};
        valid_d = 1'b1;
        state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        rd_en   = 1'b1;
        pkt_d   = {dest_q, rd_word};
        valid_d = 1'b1;
        beat_d  = beat_q + 1'b1;
`ifdef DP_TX_CHECKSUM_EN
        csum_d  = csum_q ^ rd_word;
        if (beat_q == LAST_L) state_d = S_CSUM;
`else
        if (beat_q == LAST_L) state_d = S_DONE;
`endif
      end
`ifdef DP_TX_CHECKSUM_EN
      S_CSUM: begin
        pkt_d   = {dest_q, csum_q};
        valid_d = 1'b1;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        cmpl_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop and a push in the same cycle leave the level untouched
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (wr_en && !rd_en)      level_d = level_q + 1'b1;
    else if (!wr_en && rd_en) level_d = level_q - 1'b1;
    ovf_d = ovf_q | (gpp_trf_dp && full);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= gpp_tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      dest_q   <= '0;
      beat_q   <= '0;
      pkt_q    <= '0;
      valid_q  <= 1'b0;
      cmpl_q   <= 1'b0;
      rej_q    <= 1'b0;
`ifdef DP_TX_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      dest_q   <= dest_d;
      beat_q   <= beat_d;
      pkt_q    <= pkt_d;
      valid_q  <= valid_d;
      cmpl_q   <= cmpl_d;
      rej_q    <= rej_d;
`ifdef DP_TX_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign data_tx_packet        = pkt_q;
  assign data_tx_valid         = valid_q;
  assign data_tx_complete_flag = cmpl_q;
  assign data_tx_reject        = rej_q;
  assign buf_level             = level_q;
  assign buf_full              = full;
  assign buf_empty             = (level_q == '0);
  assign buf_overflow          = ovf_q;

endmodule

// File: tb/tb_data_plane_tx_param.sv
// Scoreboard bench for data_plane_tx_param: expected tx events are queued with
// their cycle; a negedge monitor pops and compares every observed event.
module tb_data_plane_tx_param;

  localparam int DATA_W  = 16;
  localparam int NODE_W  = 16;
  localparam int DEPTH   = 16;
  localparam int PKT_LEN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        gpp_trf_dp;
  logic [15:0] gpp_tx_data;
  logic [15:0] node_id;
  logic [15:0] dest_node;
  logic        data_tx_flag;
  logic [31:0] data_tx_packet;
  logic        data_tx_valid;
  logic        data_tx_complete_flag;
  logic        data_tx_reject;
  logic [4:0]  buf_level;
  logic        buf_full;
  logic        buf_empty;
  logic        buf_overflow;

  data_plane_tx_param #(
    .DATA_W(DATA_W), .NODE_W(NODE_W), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)
  ) dut (
    .clk(clk), .rst(rst),
    .gpp_trf_dp(gpp_trf_dp), .gpp_tx_data(gpp_tx_data),
    .node_id(node_id), .dest_node(dest_node),
    .data_tx_flag(data_tx_flag),
    .data_tx_packet(data_tx_packet), .data_tx_valid(data_tx_valid),
    .data_tx_complete_flag(data_tx_complete_flag),
    .data_tx_reject(data_tx_reject),
    .buf_level(buf_level), .buf_full(buf_full),
    .buf_empty(buf_empty), .buf_overflow(buf_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // kind: 0 packet, 1 complete, 2 reject, 3 nothing
  typedef struct {
    int          kind;
    logic [31:0] pkt;
    int          cyc;
  } exp_t;
  exp_t q[$];

  always @(negedge clk) begin : monitor
    int   ak;
    exp_t e;
    ak = data_tx_valid ? 0 : data_tx_complete_flag ? 1 :
         data_tx_reject ? 2 : 3;
    if (!data_tx_valid) begin
      tests++;
      if (data_tx_packet != 32'h0) begin
        fails++;
        $display("FAIL idle_zero cyc=%0d got pkt=%h want 0", cyc, data_tx_packet);
      end
    end
    if (ak != 3 || (q.size() > 0 && q[0].cyc == cyc)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event cyc=%0d got kind=%0d pkt=%h want none",
                 cyc, ak, data_tx_packet);
      end else begin
        e = q.pop_front();
        if (ak != e.kind || data_tx_packet != e.pkt || cyc != e.cyc) begin
          fails++;
          $display("FAIL tx_event got kind=%0d pkt=%h cyc=%0d want kind=%0d pkt=%h cyc=%0d",
                   ak, data_tx_packet, cyc, e.kind, e.pkt, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic push_word(input logic [15:0] d);
    gpp_trf_dp  = 1'b1;
    gpp_tx_data = d;
    tick();
    gpp_trf_dp  = 1'b0;
  endtask

  task automatic push_exp(input int k, input logic [31:0] p, input int c);
    exp_t e;
    e.kind = k;
    e.pkt  = p;
    e.cyc  = c;
    q.push_back(e);
  endtask

  // Called one cycle before the edge that samples the start
  task automatic exp_burst(input logic [15:0] d, input logic [15:0] w0,
                           input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] w3);
    int b;
    b = cyc;
    push_exp(0, {d, node_id}, b + 2);
    push_exp(0, {d, w0}, b + 3);
    push_exp(0, {d, w1}, b + 4);
    push_exp(0, {d, w2}, b + 5);
    push_exp(0, {d, w3}, b + 6);
`ifdef DP_TX_CHECKSUM_EN
    push_exp(0, {d, w0 ^ w1 ^ w2 ^ w3}, b + 7);
    push_exp(1, 32'h0, b + 8);
`else
    push_exp(1, 32'h0, b + 7);
`endif
  endtask

  task automatic start(input logic [15:0] d);
    dest_node    = d;
    data_tx_flag = 1'b1;
    tick();
    data_tx_flag = 1'b0;
  endtask

  task automatic burst(input logic [15:0] d, input logic [15:0] w0,
                       input logic [15:0] w1, input logic [15:0] w2,
                       input logic [15:0] w3);
    exp_burst(d, w0, w1, w2, w3);
    start(d);
    wait_n(PKT_LEN + 4);
  endtask

  initial begin
    rst          = 1'b1;
    gpp_trf_dp   = 1'b1;
    gpp_tx_data  = 16'hAAAA;
    node_id      = 16'h0005;
    dest_node    = 16'h0000;
    data_tx_flag = 1'b0;

    // reset with writes active
    tick();
    tick();
    rst        = 1'b0;
    gpp_trf_dp = 1'b0;
    chk("rst_level", 32'(buf_level), 32'd0);
    chk("rst_empty", 32'(buf_empty), 32'd1);
    chk("rst_full", 32'(buf_full), 32'd0);
    chk("rst_ovf", 32'(buf_overflow), 32'd0);
    chk("rst_valid", 32'(data_tx_valid), 32'd0);
    chk("rst_pkt", data_tx_packet, 32'h0);
    chk("rst_cmpl", 32'(data_tx_complete_flag), 32'd0);
    chk("rst_rej", 32'(data_tx_reject), 32'd0);
    tick();
    chk("rst_no_write", 32'(buf_level), 32'd0);

    // nominal burst
    push_word(16'h0011);
    push_word(16'h0022);
    push_word(16'h0033);
    push_word(16'h0044);
    chk("nom_level", 32'(buf_level), 32'd4);
    burst(16'h0009, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    chk("nom_level_after", 32'(buf_level), 32'd0);
    chk("nom_empty_after", 32'(buf_empty), 32'd1);

    // reject with too few words
    push_word(16'h0101);
    push_word(16'h0202);
    push_word(16'h0303);
    push_exp(2, 32'h0, cyc + 1);
    start(16'h0009);
    wait_n(3);
    chk("rej_level", 32'(buf_level), 32'd3);
    chk("rej_valid", 32'(data_tx_valid), 32'd0);

    // full / overflow
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_level", 32'(buf_level), 32'd0);
    for (int i = 1; i <= 17; i++) push_word(16'h1000 + 16'(i));
    chk("full_flag", 32'(buf_full), 32'd1);
    chk("full_level", 32'(buf_level), 32'd16);
    chk("full_ovf", 32'(buf_overflow), 32'd1);
    chk("full_empty", 32'(buf_empty), 32'd0);
    burst(16'h0009, 16'h1001, 16'h1002, 16'h1003, 16'h1004);
    chk("drain_level", 32'(buf_level), 32'd12);
    chk("drain_ovf_sticky", 32'(buf_overflow), 32'd1);
    chk("drain_full", 32'(buf_full), 32'd0);
    burst(16'h0009, 16'h1005, 16'h1006, 16'h1007, 16'h1008);
    burst(16'h0009, 16'h1009, 16'h100A, 16'h100B, 16'h100C);
    chk("drain2_level", 32'(buf_level), 32'd4);

    // write pointer wraps; writes every cycle during a burst
    push_word(16'h2001);
    push_word(16'h2002);
    chk("wrap_level", 32'(buf_level), 32'd6);
    exp_burst(16'h0007, 16'h100D, 16'h100E, 16'h100F, 16'h1010);
    dest_node = 16'h0007;
    for (int i = 0; i < 6; i++) begin
      gpp_trf_dp   = 1'b1;
      gpp_tx_data  = 16'h3001 + 16'(i);
      data_tx_flag = (i == 0) || (i == 3);
      tick();
      if (i >= 2) chk("conc_level", 32'(buf_level), 32'd8);
    end
    gpp_trf_dp   = 1'b0;
    data_tx_flag = 1'b0;
    wait_n(PKT_LEN);
    chk("conc_level_after", 32'(buf_level), 32'd8);
    burst(16'h0007, 16'h2001, 16'h2002, 16'h3001, 16'h3002);
    burst(16'h0007, 16'h3003, 16'h3004, 16'h3005, 16'h3006);
    chk("wrap_empty", 32'(buf_empty), 32'd1);

    // reset during second payload beat
    push_word(16'h4001);
    push_word(16'h4002);
    push_word(16'h4003);
    push_word(16'h4004);
    exp_burst(16'h0009, 16'h4001, 16'h4002, 16'h4003, 16'h4004);
    start(16'h0009);
    wait_n(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    chk("mid_rst_valid", 32'(data_tx_valid), 32'd0);
    chk("mid_rst_pkt", data_tx_packet, 32'h0);
    chk("mid_rst_cmpl", 32'(data_tx_complete_flag), 32'd0);
    chk("mid_rst_level", 32'(buf_level), 32'd0);
    chk("mid_rst_empty", 32'(buf_empty), 32'd1);
    chk("mid_rst_ovf", 32'(buf_overflow), 32'd0);
    wait_n(8);

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_plane_tx_param.md
Name: data_plane_tx_param

Overview:
Parametrised data-plane transmitter for the communications processor. The GPP pushes payload words into a local FIFO buffer. On a start pulse from the control plane, the block emits one header packet followed by a fixed-length burst of payload packets on the data-plane tx bus, then pulses a completion flag back to the control plane. It generalises the fixed 16-bit, 4-packet transmitter with configurable widths, depth and burst length, FIFO ordering, full/empty/overflow status, and start rejection.

Parameters:
DATA_W, 16, payload word width
NODE_W, 16, node id width; packet width is NODE_W+DATA_W
DEPTH, 16, buffer entries; power of 2, >= PKT_LEN
PKT_LEN, 4, payload packets per burst (1..DEPTH)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
gpp_trf_dp  in  1  write strobe: push gpp_tx_data into buffer this cycle
gpp_tx_data  in  DATA_W  payload word from GPP
node_id  in  NODE_W  this node's id (source)
dest_node  in  NODE_W  destination id, sampled on accepted start
data_tx_flag  in  1  one-cycle start request from control plane
data_tx_packet  out  NODE_W+DATA_W  tx bus word; zero when idle
data_tx_valid  out  1  high while data_tx_packet carries header/payload
data_tx_complete_flag  out  1  one-cycle pulse after burst ends
data_tx_reject  out  1  one-cycle pulse: start refused
buf_level  out  clog2(DEPTH)+1  words currently buffered
buf_full  out  1  buf_level == DEPTH
buf_empty  out  1  buf_level == 0
buf_overflow  out  1  sticky: write attempted while full

Behaviour:
- Reset (sync, rst=1 at posedge): all outputs 0. FIFO pointers/level 0, state IDLE, latched dest 0. Reset mid-burst aborts immediately: no complete pulse, buffer contents discarded.
- Buffer: circular FIFO, write/read pointers wrap mod DEPTH. Write when gpp_trf_dp=1 and not full. Write while full is dropped and sets buf_overflow (cleared only by rst). Simultaneous write and burst read in the same cycle are both performed; level is unchanged.
- FSM states: IDLE, HEADER, PAYLOAD, DONE.
- IDLE: data_tx_flag=1 and buf_level>=PKT_LEN -> latch dest_node, go to HEADER. data_tx_flag=1 and buf_level<PKT_LEN -> data_tx_reject pulse next cycle, stay IDLE. data_tx_flag while not IDLE is ignored, with no reject.
- HEADER, 1 cycle: data_tx_packet={dest,node_id}, valid=1 -> PAYLOAD.
- PAYLOAD, PKT_LEN cycles: word k = {dest, k-th oldest buffered word}, valid=1. Each word pops one entry. Beat counter reaches PKT_LEN-1 -> DONE.
- DONE, 1 cycle: packet=0, valid=0, data_tx_complete_flag=1 -> IDLE.
- Latency: start sampled at edge T -> header visible after edge T+1, payload after edges T+2..T+1+PKT_LEN, complete pulse after edge T+2+PKT_LEN. The next start is accepted at the DONE edge at the earliest.
- Outputs are registered. data_tx_packet=0 whenever valid=0.
- Words written during a burst are not part of that burst unless already counted. The burst consumes exactly the PKT_LEN oldest entries.

Optional Feature:
DP_TX_CHECKSUM_EN. When defined, an extra CSUM state sits between PAYLOAD and DONE. It emits {dest, XOR of the PKT_LEN payload words} with valid=1, so the burst is PKT_LEN+2 valid cycles and the complete pulse shifts one cycle later. When undefined, there is no CSUM state and the timing is as above.

Test Plan:
- Reset: rst=1 for 2 cycles with writes active -> all outputs 0, buf_empty=1, no write retained.
- Nominal: push 0x0011,0x0022,0x0033,0x0044 with node_id=0x0005, then start with dest_node=0x0009 -> packets 0x00090005, 0x00090011, 0x00090022, 0x00090033, 0x00090044 on consecutive cycles, then complete pulse for 1 cycle, buf_empty=1.
- Reject: push 3 words, start -> data_tx_reject pulse, valid stays 0, buf_level=3.
- Full/overflow (DEPTH=16): push 17 words -> buf_full=1, buf_level=16, buf_overflow=1; burst then drains words 1..4 in order and the 17th never appears.
- Concurrent write and wrap: pointers near DEPTH-1, writes every cycle during a burst -> payload order preserved across wrap, buf_level unchanged during PAYLOAD; start pulses mid-burst ignored.
- Reset mid-burst: rst asserted during second payload beat -> next cycle all outputs 0, no complete pulse; with DP_TX_CHECKSUM_EN, the nominal case adds a 0x00090044 checksum word (0x11^0x22^0x33^0x44=0x44) before the complete pulse.
